// File: rtl/wb_mem_responder.sv
// Wishbone memory-side responder holding 128-bit lines; each request is answered
// with ACK (in range) or RTY (out of range) a fixed LATENCY cycles after sampling.
module wb_mem_responder #(
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned ADDR_LINES_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         CYC,
    input  logic         STB,
    input  logic         WE,
    input  logic [15:0]  SEL,
    input  logic [31:0]  ADR,
    input  logic [127:0] DAT_M,
    output logic [127:0] DAT_S,
    output logic         ACK,
    output logic         RTY
);

    localparam int unsigned NUM_LINES = 1 << ADDR_LINES_LOG2;
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND,
        S_RECOVER
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [27:0]    line_q, line_d;
    logic           we_q, we_d;
    logic [15:0]    sel_q, sel_d;
    logic [127:0]   wdat_q, wdat_d;
    logic           ack_q, ack_d;
    logic           rty_q, rty_d;
    logic [127:0]   rdat_q, rdat_d;
    logic           mem_we;
    logic           in_range;
    logic [ADDR_LINES_LOG2-1:0] mem_idx;
    logic           unused_adr_bits;

    // Storage is deliberately outside the reset domain so contents survive rst.
    logic [127:0]   mem [NUM_LINES];

    assign in_range        = (line_q >> ADDR_LINES_LOG2) == 28'd0;
    assign mem_idx         = line_q[ADDR_LINES_LOG2-1:0];
    assign unused_adr_bits = ^ADR[3:0];

    assign ACK   = ack_q;
    assign RTY   = rty_q;
    assign DAT_S = rdat_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        rty_d   = 1'b0;
        rdat_d  = '0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CYC && STB) begin
                    line_d  = ADR[31:4];
                    we_d    = WE;
                    sel_d   = SEL;
                    wdat_d  = DAT_M;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A dropped CYC wins over an expiring counter: nothing is committed.
                if (!CYC) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                    if (in_range) begin
                        ack_d  = 1'b1;
                        mem_we = we_q;
                        if (!we_q) begin
                            rdat_d = mem[mem_idx];
                        end
                    end else begin
                        rty_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            line_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            rty_q   <= rty_d;
            rdat_q  <= rdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 16; i++) begin
                if (sel_q[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdat_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed and randomized checks of wb_mem_responder against a line-array model
// that applies byte-enable writes and answers reads/range refusals by rule.
module tb_wb_mem_responder;

    localparam int LAT   = 4;
    localparam int ALW   = 8;
    localparam int LINES = 1 << ALW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         CYC = 1'b0;
    logic         STB = 1'b0;
    logic         WE  = 1'b0;
    logic [15:0]  SEL = '0;
    logic [31:0]  ADR = '0;
    logic [127:0] DAT_M = '0;
    logic [127:0] DAT_S;
    logic         ACK;
    logic         RTY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] model [LINES];

    wb_mem_responder #(.LATENCY(LAT), .ADDR_LINES_LOG2(ALW)) dut (
        .clk   (clk),
        .rst   (rst),
        .CYC   (CYC),
        .STB   (STB),
        .WE    (WE),
        .SEL   (SEL),
        .ADR   (ADR),
        .DAT_M (DAT_M),
        .DAT_S (DAT_S),
        .ACK   (ACK),
        .RTY   (RTY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one request and wait (bounded) for its response; inputs are scrambled after sampling.
    task automatic do_req(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                          input logic [127:0] dat, output int lat, output logic got_ack,
                          output logic got_rty, output logic [127:0] rdata);
        @(negedge clk);
        CYC = 1'b0; STB = 1'b0;
        @(negedge clk);
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_M = dat;
        @(posedge clk);
        #1;
        STB = 1'b0; WE = ~we; ADR = $urandom; SEL = 16'($urandom); DAT_M = rnd128();
        lat = -1; got_ack = 1'b0; got_rty = 1'b0; rdata = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ACK || RTY) begin
                lat = k; got_ack = ACK; got_rty = RTY; rdata = DAT_S;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("resp_one_cycle", {ACK, RTY, DAT_S}, 130'd0);
        CYC = 1'b0;
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                       input logic [15:0] sel, input logic [127:0] dat);
        int           lat;
        logic         a, r;
        logic [127:0] rd;
        logic [127:0] exp_d;
        logic [27:0]  line;
        logic         inr;
        line = adr[31:4];
        inr  = line < 28'(LINES);
        exp_d = (!we && inr) ? model[line[ALW-1:0]] : 128'd0;
        do_req(we, adr, sel, dat, lat, a, r, rd);
        check({tag, "_latency"}, 128'(lat), 128'(LAT));
        check({tag, "_ack_rty"}, {126'd0, a, r}, {126'd0, inr, ~inr});
        check({tag, "_dat_s"}, rd, exp_d);
        if (we && inr) begin
            for (int i = 0; i < 16; i++) begin
                if (sel[i]) model[line[ALW-1:0]][8*i +: 8] = dat[8*i +: 8];
            end
        end
    endtask

    task automatic watch_quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (ACK || RTY || (DAT_S != 128'd0)) seen = 1'b1;
        end
        check(tag, {127'd0, seen}, 128'd0);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] d1, d2;
        logic [27:0]  line;
        int           n_ack, t1, t2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ACK, RTY, DAT_S}, 130'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full write then read of line 0x12
        txn("wr_full", 1'b1, 32'h0000_0120, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF);
        txn("rd_full", 1'b0, 32'h0000_0120, 16'h0000, 128'd0);

        // Partial write of the low byte only
        txn("preload_aa", 1'b1, 32'h0000_0120, 16'hFFFF, {16{8'hAA}});
        d = rnd128();
        d[7:0] = 8'h55;
        txn("wr_partial", 1'b1, 32'h0000_0120, 16'h0001, d);
        txn("rd_partial", 1'b0, 32'h0000_0120, 16'hFFFF, 128'd0);
        check("partial_value", model[8'h12], {{15{8'hAA}}, 8'h55});

        // Out-of-range requests refuse and must not alias onto low lines
        txn("pre_line0", 1'b1, 32'h0000_0000, 16'hFFFF, rnd128());
        txn("pre_line1", 1'b1, 32'h0000_0010, 16'hFFFF, rnd128());
        txn("oor_read", 1'b0, 32'h0000_1000, 16'hFFFF, 128'd0);
        txn("oor_write", 1'b1, 32'h0000_1010, 16'hFFFF, rnd128());
        txn("rd_line0", 1'b0, 32'h0000_0000, 16'h0000, 128'd0);
        txn("rd_line1", 1'b0, 32'h0000_0010, 16'h0000, 128'd0);

        // Abort: CYC dropped two cycles after sampling
        @(negedge clk);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 32'h0000_0120; SEL = 16'hFFFF; DAT_M = rnd128();
        @(posedge clk);
        #1;
        STB = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        CYC = 1'b0;
        watch_quiet("abort_no_resp", 10);
        txn("abort_rd", 1'b0, 32'h0000_0120, 16'h0000, 128'd0);

        // Reset in the middle of a write's WAIT phase
        txn("pre_line20", 1'b1, 32'h0000_0200, 16'hFFFF, rnd128());
        @(negedge clk);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 32'h0000_0200; SEL = 16'hFFFF; DAT_M = rnd128();
        @(posedge clk);
        #1;
        STB = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {ACK, RTY, DAT_S}, 130'd0);
        @(negedge clk);
        CYC = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        watch_quiet("rst_no_resp", 10);
        txn("rst_rd", 1'b0, 32'h0000_0200, 16'h0000, 128'd0);

        // Back-to-back reads with CYC/STB held high
        @(negedge clk);
        CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h0000_0000; SEL = 16'($urandom);
        n_ack = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ACK) begin
                if (n_ack == 0) begin
                    t1 = cyc; d1 = DAT_S; ADR = 32'h0000_0010;
                end else begin
                    t2 = cyc; d2 = DAT_S; CYC = 1'b0; STB = 1'b0;
                end
                n_ack++;
                if (n_ack == 2) break;
            end
        end
        CYC = 1'b0; STB = 1'b0;
        check("b2b_count", 128'(n_ack), 128'd2);
        // Rising edges LAT+3 apart, i.e. LAT+2 cycles from first ACK falling to second rising.
        check("b2b_spacing", 128'(t2 - t1), 128'(LAT + 3));
        check("b2b_data0", d1, model[0]);
        check("b2b_data1", d2, model[1]);
        watch_quiet("b2b_no_third", 12);

        // Randomized traffic over a small window of lines plus occasional out-of-range
        for (int i = 0; i < 16; i++) begin
            txn("rnd_init", 1'b1, {24'd0, 4'(i), 4'($urandom)}, 16'hFFFF, rnd128());
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) line = 28'($urandom_range(LINES, 4000));
            else line = 28'($urandom_range(0, 15));
            txn("rnd", 1'($urandom_range(0, 1)), {line, 4'($urandom)}, 16'($urandom), rnd128());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
